// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute, ALU and immediate decode, retire counter.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_o.
module multicycle_controller #(
  parameter int INSTRET_W = 32,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic [INSTRET_W-1:0] instret,
  output logic [STATE_W-1:0]   state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_o
`endif
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);
`endif

  logic [STATE_W-1:0]   state_reg, state_next;
  logic [INSTRET_W-1:0] instret_reg;
  logic                 pc_update, branch, mem_write_raw, ir_write_raw, reg_write_raw, retire;
  logic [1:0]           alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECUTER;
          7'b0010011:             state_next = S_EXECUTEI;
          7'b1100011:             state_next = S_BEQ;
          7'b1101111:             state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:                state_next = S_TRAP;
`else
          default:                state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire        = mem_ready;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are suppressed during reset so an abandoned instruction leaves no trace.
  assign PCWrite  = ~reset & ((branch & zero) | pc_update);
  assign MemWrite = ~reset & mem_write_raw;
  assign IRWrite  = ~reset & ir_write_raw;
  assign RegWrite = ~reset & reg_write_raw;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  assign instret = instret_reg;
  assign state_o = state_reg;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o = (state_reg == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction latency, strobe counts and decode
// compared against a behavioural model driven from the instruction-level timing rules.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] instret;
  logic [3:0] state_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_o;
`endif

  int total = 0;
  int bad = 0;
  logic [3:0] model_instret = 4'd0;
  int seq_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.INSTRET_W(4), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .instret(instret), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  // 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unknown
  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic logic [2:0] alu_model(input int k, input logic [2:0] f3, input logic f7);
    if (k == 4) return 3'b001;
    case (f3)
      3'b000:  return (k == 2 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_model(input int k);
    case (k)
      1: return 2'b01;
      4: return 2'b10;
      5: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Runs one instruction from FETCH: fw not-ready cycles in fetch, mw not-ready cycles in the memory phase.
  task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw);
    int k, lat, n_pc, n_ir, n_rw, n_mw, exp_pc, exp_rw, exp_mw;
    logic [3:0] exp_final;
    k = kind_of(op_i);
    case (k)
      0: lat = 5 + fw + mw;
      1: lat = 4 + fw + mw;
      2, 3, 5: lat = 4 + fw;
      4: lat = 3 + fw;
      default: lat = 2 + fw;
    endcase
    op = op_i; funct3 = f3; funct7b5 = f7; zero = z;
    n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0;
    seq_q.delete();
    for (int c = 0; c < lat; c++) begin
      if (c < fw) mem_ready = 1'b0;
      else if (k <= 1 && c >= fw + 3 && c < fw + 3 + mw) mem_ready = 1'b0;
      else mem_ready = 1'b1;
      @(negedge clk);
      seq_q.push_back(int'(state_o));
      n_pc += int'(PCWrite); n_ir += int'(IRWrite);
      n_rw += int'(RegWrite); n_mw += int'(MemWrite);
      total++;
      if (ImmSrc !== imm_model(k)) begin
        bad++; $display("FAIL immsrc op=%b got=%b want=%b", op_i, ImmSrc, imm_model(k));
      end
      if (c == fw + 2 && (k == 2 || k == 3 || k == 4)) begin
        total++;
        if (ALUControl !== alu_model(k, f3, f7)) begin
          bad++; $display("FAIL alucontrol op=%b f3=%b f7=%b got=%b want=%b", op_i, f3, f7, ALUControl, alu_model(k, f3, f7));
        end
      end
      if (RegWrite && k == 0) begin
        total++;
        if (ResultSrc !== 2'b01) begin bad++; $display("FAIL lw_resultsrc got=%b want=01", ResultSrc); end
      end
      if (MemWrite) begin
        total++;
        if (AdrSrc !== 1'b1) begin bad++; $display("FAIL sw_adrsrc got=%b want=1", AdrSrc); end
      end
      if (c == lat - 1) begin
        total++;
        if (state_o === 4'd0) begin bad++; $display("FAIL latency op=%b back in fetch early at cycle %0d of %0d", op_i, c, lat); end
      end
      @(posedge clk); #1;
    end
    if (k != 6) model_instret = model_instret + 4'd1;
    exp_pc = 1 + ((k == 4 && z) ? 1 : 0) + ((k == 5) ? 1 : 0);
    exp_rw = (k == 0 || k == 2 || k == 3 || k == 5) ? 1 : 0;
    exp_mw = (k == 1) ? mw + 1 : 0;
`ifdef ILLEGAL_TRAP_EN
    exp_final = (k == 6) ? 4'd11 : 4'd0;
`else
    exp_final = 4'd0;
`endif
    total += 6;
    if (state_o !== exp_final) begin bad++; $display("FAIL end_state op=%b got=%0d want=%0d", op_i, state_o, exp_final); end
    if (instret !== model_instret) begin bad++; $display("FAIL instret op=%b got=%0d want=%0d", op_i, instret, model_instret); end
    if (n_pc != exp_pc) begin bad++; $display("FAIL pcwrite_count op=%b got=%0d want=%0d", op_i, n_pc, exp_pc); end
    if (n_ir != 1) begin bad++; $display("FAIL irwrite_count op=%b got=%0d want=1", op_i, n_ir); end
    if (n_rw != exp_rw) begin bad++; $display("FAIL regwrite_count op=%b got=%0d want=%0d", op_i, n_rw, exp_rw); end
    if (n_mw != exp_mw) begin bad++; $display("FAIL memwrite_count op=%b got=%0d want=%0d", op_i, n_mw, exp_mw); end
    $display("instr op=%b f3=%b fw=%0d mw=%0d cycles=%0d instret=%0d", op_i, f3, fw, mw, lat, instret);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
        bad++; $display("FAIL reset_strobes got=%b want=0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_instret = 4'd0;
    total += 2;
    if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    if (instret !== 4'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
  endtask

  task automatic test_load();
    int exp_seq[5] = '{0, 1, 2, 3, 4};
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (seq_q[i] != exp_seq[i]) begin bad++; $display("FAIL lw_state_seq idx=%0d got=%0d want=%0d", i, seq_q[i], exp_seq[i]); end
    end
  endtask

  task automatic test_store_stall();
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2);
  endtask

  task automatic test_alu_decode();
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 1, 0);
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    repeat (3) begin
      @(negedge clk);
      total += 2;
      if (illegal_o !== 1'b1) begin bad++; $display("FAIL trap_illegal got=%b want=1", illegal_o); end
      if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
        bad++; $display("FAIL trap_strobes got=%b want=0000", {PCWrite, MemWrite, IRWrite, RegWrite});
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    model_instret = 4'd0;
    total += 2;
    if (state_o !== 4'd0) begin bad++; $display("FAIL trap_exit got=%0d want=0", state_o); end
    if (illegal_o !== 1'b0) begin bad++; $display("FAIL illegal_after_reset got=%b want=0", illegal_o); end
`endif
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
      bad++; $display("FAIL midreset_strobes got=%b want=0000", {PCWrite, MemWrite, IRWrite, RegWrite});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_instret = 4'd0;
    total += 2;
    if (state_o !== 4'd0) begin bad++; $display("FAIL midreset_state got=%0d want=0", state_o); end
    if (instret !== 4'd0) begin bad++; $display("FAIL midreset_instret got=%0d want=0", instret); end
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_wrap();
    while (model_instret != 4'hF) run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    total++;
    if (instret !== 4'd0) begin bad++; $display("FAIL instret_wrap got=%0d want=0", instret); end
  endtask

  task automatic test_random();
    logic [6:0] ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(5)], 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(2)), int'($urandom_range(3)));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_stall();
    test_alu_decode();
    test_branch();
    test_reset_mid();
    test_wrap();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
